// File: rtl/alu_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// alu_cmd_sequencer
//   Command-side initiator for a combinational WIDTH-bit ALU (AND/OR/ADD with
//   carry-out and zero flags). It accepts one operation over a valid/ready
//   command port and drives the ALU operands and select. It then registers the
//   ALU result and flags and returns them over a valid/ready response port.
//
//   The ALU add path has no carry-in. SUB is therefore done in two passes:
//     1. Negate B: 1 + ~B.
//     2. Add A to the negated B.
//   The no-borrow flag is the OR of the two carry-outs.
//
//   Build option: define ALU_CMD_SUB_EN to build the SUB sequence (the NEG
//   state and the c1 carry register). When it is undefined, op 11 runs one
//   pass with the ALU idle select. It returns data 0, z 1, c 0.
//
//   Ports
//     clk, rst_n              clock, asynchronous active-low reset
//     cmd_valid/cmd_ready     command handshake
//     cmd_op                  00 AND, 01 OR, 10 ADD, 11 SUB
//     cmd_a, cmd_b            operands
//     alu_a, alu_b, alu_sel   drive to ALU (registered)
//     alu_out, alu_cout, alu_z  ALU result and flags
//     rsp_valid/rsp_ready     response handshake
//     rsp_data, rsp_z, rsp_c  registered result, zero flag, carry/no-borrow
//
//   FSM states
//     state  | meaning
//     IDLE   | ready for a command
//     NEG    | SUB pass 1: ALU computes -B
//     EXEC   | ALU computes the requested operation; result captured
//     RESP   | response held until rsp_ready
// -----------------------------------------------------------------------------
module alu_cmd_sequencer #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_sel,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_cout,
  input  logic             alu_z,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_z,
  output logic             rsp_c
);

  localparam logic [3:0] SEL_AND  = 4'b0000;
  localparam logic [3:0] SEL_OR   = 4'b0001;
  localparam logic [3:0] SEL_ADD  = 4'b0010;
  localparam logic [3:0] SEL_IDLE = 4'b1111;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;
  localparam logic [1:0] OP_SUB = 2'b11;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
`ifdef ALU_CMD_SUB_EN
    S_RESP = 2'd2,
    S_NEG  = 2'd3
`else
    S_RESP = 2'd2
`endif
  } state_t;

  state_t           r_state;
  logic [1:0]       r_op;
  logic             r_cmd_ready;
  logic             r_rsp_valid;
  logic [WIDTH-1:0] r_rsp_data;
  logic             r_rsp_z;
  logic             r_rsp_c;
  logic [WIDTH-1:0] r_alu_a;
  logic [WIDTH-1:0] r_alu_b;
  logic [3:0]       r_alu_sel;
`ifdef ALU_CMD_SUB_EN
  logic [WIDTH-1:0] r_a;   // A is parked here while the ALU negates B
  logic             r_c1;  // carry-out of the negate pass
`endif

  // Select for a single-pass operation. Without SUB support, op 11 maps to the
  // idle select, so the ALU returns 0.
  function automatic logic [3:0] sel_for(input logic [1:0] op);
    case (op)
      OP_AND:  sel_for = SEL_AND;
      OP_OR:   sel_for = SEL_OR;
      OP_ADD:  sel_for = SEL_ADD;
`ifdef ALU_CMD_SUB_EN
      default: sel_for = SEL_ADD;
`else
      default: sel_for = SEL_IDLE;
`endif
    endcase
  endfunction

  // The ALU drive is registered. It is loaded on the edge that enters
  // NEG/EXEC, so there is no combinational path from cmd_* to alu_*.
  // Register r_alu_b also serves as the B register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_op        <= OP_AND;
      r_cmd_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_z     <= 1'b0;
      r_rsp_c     <= 1'b0;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_sel   <= SEL_IDLE;
`ifdef ALU_CMD_SUB_EN
      r_a         <= '0;
      r_c1        <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cmd_valid && r_cmd_ready) begin
            r_op        <= cmd_op;
            r_cmd_ready <= 1'b0;
`ifdef ALU_CMD_SUB_EN
            r_a         <= cmd_a;
            if (cmd_op == OP_SUB) begin
              r_state   <= S_NEG;
              r_alu_a   <= ONE;
              r_alu_b   <= ~cmd_b;
              r_alu_sel <= SEL_ADD;
            end else begin
              r_state   <= S_EXEC;
              r_alu_a   <= cmd_a;
              r_alu_b   <= cmd_b;
              r_alu_sel <= sel_for(cmd_op);
            end
`else
            r_state     <= S_EXEC;
            r_alu_sel   <= sel_for(cmd_op);
            if (cmd_op == OP_SUB) begin
              r_alu_a   <= '0;
              r_alu_b   <= '0;
            end else begin
              r_alu_a   <= cmd_a;
              r_alu_b   <= cmd_b;
            end
`endif
          end
        end
`ifdef ALU_CMD_SUB_EN
        S_NEG: begin
          r_c1      <= alu_cout;
          r_alu_a   <= r_a;
          r_alu_b   <= alu_out;  // -B mod 2^WIDTH
          r_alu_sel <= SEL_ADD;
          r_state   <= S_EXEC;
        end
`endif
        S_EXEC: begin
          r_rsp_data  <= alu_out;
          r_rsp_z     <= alu_z;
          case (r_op)
            OP_ADD:  r_rsp_c <= alu_cout;
`ifdef ALU_CMD_SUB_EN
            OP_SUB:  r_rsp_c <= alu_cout | r_c1;
`endif
            default: r_rsp_c <= 1'b0;
          endcase
          r_rsp_valid <= 1'b1;
          r_alu_a     <= '0;
          r_alu_b     <= '0;
          r_alu_sel   <= SEL_IDLE;
          r_state     <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_cmd_ready <= 1'b1;
          r_rsp_valid <= 1'b0;
          r_alu_a     <= '0;
          r_alu_b     <= '0;
          r_alu_sel   <= SEL_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_z     = r_rsp_z;
  assign rsp_c     = r_rsp_c;
  assign alu_a     = r_alu_a;
  assign alu_b     = r_alu_b;
  assign alu_sel   = r_alu_sel;

endmodule
